// File: rtl/iota_wb_sequencer_if.sv
// Bus bundle between the iota engine, the writeback sequencer and the VRF
// write port. The sequencer sits on the slave side and the producer/VRF
// environment on the master side.
interface iota_wb_sequencer_if #(
  parameter int BEAT_W = 1
);
  logic              in_valid;
  logic [31:0]       in_res0;
  logic [31:0]       in_res1;
  logic              in_ready;
  logic              wstall;
  logic              wen;
  logic [4:0]        wreg;
  logic [BEAT_W-1:0] wbeat;
  logic [63:0]       wdata;
  logic [7:0]        wstrb;

  modport slave (
    input  in_valid, in_res0, in_res1, wstall,
    output in_ready, wen, wreg, wbeat, wdata, wstrb
  );

  modport master (
    output in_valid, in_res0, in_res1, wstall,
    input  in_ready, wen, wreg, wbeat, wdata, wstrb
  );
endinterface

// File: rtl/iota_wb_sequencer.sv
// Writeback sequencer for the iota engine: takes packed 64-bit result beats,
// buffers them in a 2-entry skid FIFO and issues byte-strobed VRF writes
// with vl tail and v0.t masking applied per element.
module iota_wb_sequencer #(
  parameter int VLEN = 128
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  start,
  input  logic [4:0]            vd,
  input  logic [1:0]            sew,
  input  logic [6:0]            vl,
  input  logic                  vm,
  input  logic [63:0]           vmask,
  iota_wb_sequencer_if.slave    bus,
  output logic                  busy,
  output logic                  done
);

  localparam int BEATS_PER_REG = VLEN / 64;
  localparam int BEAT_W        = (BEATS_PER_REG > 1) ? $clog2(BEATS_PER_REG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  logic [4:0]  vd_q;
  logic [1:0]  elog_q;
  logic [6:0]  vl_q;
  logic        vm_q;
  logic [63:0] vmask_q;
  logic [6:0]  n_beats;

  logic [1:0]  elog_in;
  logic [7:0]  vl_round;
  logic [6:0]  n_in;

  logic [6:0]  in_cnt;
  logic [6:0]  out_cnt;

  logic [63:0] fifo_data [2];
  logic [6:0]  fifo_idx  [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  fifo_cnt;

  logic        push;
  logic        pop;
  logic        write_fire;
  logic        launch;

  logic              wen_q;
  logic [4:0]        wreg_q;
  logic [BEAT_W-1:0] wbeat_q;
  logic [63:0]       wdata_q;
  logic [7:0]        wstrb_q;

  logic [6:0]        head_idx;
  logic [31:0]       idx_ext;
  logic [4:0]        reg_nxt;
  logic [BEAT_W-1:0] beat_nxt;
  logic [7:0]        strb_nxt;
  logic [8:0]        elem;

  // log2 of elements per beat and the rounded-up beat count for the new op
  always_comb begin
    case (sew)
      2'd0:    elog_in = 2'd3;
      2'd1:    elog_in = 2'd2;
      default: elog_in = 2'd1;
    endcase
    vl_round = {1'b0, vl} + ((8'd1 << elog_in) - 8'd1);
    n_in     = 7'(vl_round >> elog_in);
  end

  assign launch     = (state == IDLE) && start;
  assign bus.in_ready = (state == RUN) && (in_cnt < n_beats) && (fifo_cnt < 2'd2);
  assign push       = bus.in_valid && bus.in_ready;
  assign write_fire = wen_q && !bus.wstall;
  assign pop        = (fifo_cnt != 2'd0) && (!wen_q || !bus.wstall);

  // FSM state register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state: accept beats, drain the writes, pulse done once
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (in_cnt == n_beats) state_nxt = DRAIN;
      DRAIN:   if (out_cnt == n_beats) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operation configuration captured on an accepted start
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      vd_q    <= '0;
      elog_q  <= 2'd1;
      vl_q    <= '0;
      vm_q    <= 1'b0;
      vmask_q <= '0;
      n_beats <= '0;
    end else if (launch) begin
      vd_q    <= vd;
      elog_q  <= elog_in;
      vl_q    <= vl;
      vm_q    <= vm;
      vmask_q <= vmask;
      n_beats <= n_in;
    end
  end

  // Accepted-beat and completed-write counters
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      in_cnt  <= '0;
      out_cnt <= '0;
    end else if (launch) begin
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      if (push)       in_cnt  <= in_cnt + 7'd1;
      if (write_fire) out_cnt <= out_cnt + 7'd1;
    end
  end

  // Two-entry skid FIFO holding beat data together with its beat index
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int e = 0; e < 2; e++) begin
        fifo_data[e] <= '0;
        fifo_idx[e]  <= '0;
      end
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= {bus.in_res1, bus.in_res0};
        fifo_idx[wr_ptr]  <= in_cnt;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Register target, slot and per-byte strobes for the FIFO head beat
  always_comb begin
    head_idx = fifo_idx[rd_ptr];
    idx_ext  = 32'(head_idx);
    reg_nxt  = vd_q + 5'(idx_ext / BEATS_PER_REG);
    beat_nxt = BEAT_W'(idx_ext % BEATS_PER_REG);
    strb_nxt = '0;
    elem     = '0;
    for (int b = 0; b < 8; b++) begin
      elem = ({2'b00, head_idx} << elog_q) + (9'(b) >> (2'd3 - elog_q));
      if ((elem < {2'b00, vl_q}) && (vm_q || vmask_q[elem[5:0]]))
        strb_nxt[b] = 1'b1;
    end
  end

  // Output write register: loads from the FIFO head, holds while stalled
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wen_q   <= 1'b0;
      wreg_q  <= '0;
      wbeat_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (pop) begin
      wen_q   <= 1'b1;
      wreg_q  <= reg_nxt;
      wbeat_q <= beat_nxt;
      wdata_q <= fifo_data[rd_ptr];
      wstrb_q <= strb_nxt;
    end else if (write_fire) begin
      wen_q   <= 1'b0;
    end
  end

  assign bus.wen   = wen_q;
  assign bus.wreg  = wreg_q;
  assign bus.wbeat = wbeat_q;
  assign bus.wdata = wdata_q;
  assign bus.wstrb = wstrb_q;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_iota_wb_sequencer.sv
// Self-checking bench for iota_wb_sequencer: table of operations with a
// write scoreboard, plus hand sequences for reset behaviour.
module tb_iota_wb_sequencer;

  localparam int VLEN   = 128;
  localparam int BPR    = VLEN / 64;
  localparam int BEAT_W = 1;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        start;
  logic [4:0]  vd;
  logic [1:0]  sew;
  logic [6:0]  vl;
  logic        vm;
  logic [63:0] vmask;
  logic        busy;
  logic        done;

  iota_wb_sequencer_if #(.BEAT_W(BEAT_W)) bus ();

  iota_wb_sequencer #(.VLEN(VLEN)) dut (
    .CLK   (CLK),
    .nRST  (nRST),
    .start (start),
    .vd    (vd),
    .sew   (sew),
    .vl    (vl),
    .vm    (vm),
    .vmask (vmask),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  vd;
    logic [1:0]  sew;
    logic [6:0]  vl;
    logic        vm;
    logic [63:0] vmask;
    int          exp_n;
    logic [7:0]  strb_first;
    logic [7:0]  strb_last;
    logic [4:0]  reg_last;
    int          stall_at;
    int          stall_len;
    int          restart_at;
  } vec_t;

  typedef struct packed {
    logic [4:0]        wreg;
    logic [BEAT_W-1:0] wbeat;
    logic [63:0]       wdata;
    logic [7:0]        wstrb;
  } wr_t;

  wr_t  sb[$];
  vec_t vecs[9];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_strb(input int k, input logic [1:0] s, input logic [6:0] l,
                                            input logic m, input logic [63:0] mask);
    int e;
    int bpe;
    int i;
    logic [7:0] r;
    e   = (s == 2'd0) ? 8 : (s == 2'd1) ? 4 : 2;
    bpe = 8 / e;
    r   = '0;
    for (int byt = 0; byt < 8; byt++) begin
      i = k * e + byt / bpe;
      if (i < int'(l) && i < 64) begin
        if (m || mask[i]) r[byt] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic apply_stimulus(input vec_t v, input string tag);
    int k = 0;
    int completed = 0;
    int writes = 0;
    int done_cnt = 0;
    int done_obs = -1;
    int last_c = -1;
    int first_acc = -1;
    int first_wen = -1;
    int skid;
    bit finished = 0;
    bit exp_busy;
    bit prev_stalled = 0;
    wr_t prev;
    wr_t cur;
    wr_t exp_w;
    logic [7:0]  first_strb = '0;
    logic [7:0]  last_strb = '0;
    logic [4:0]  last_reg = '0;
    logic [63:0] beat_data;

    sb.delete();
    beat_data = {$urandom, $urandom};
    @(negedge CLK);
    start = 1'b1; vd = v.vd; sew = v.sew; vl = v.vl; vm = v.vm; vmask = v.vmask;
    for (int c = 0; c < 300 && !finished; c++) begin
      @(negedge CLK);
      start = (c == v.restart_at);
      vd    = (c == v.restart_at) ? ~v.vd : v.vd;
      vl    = (c == v.restart_at) ? 7'd1 : v.vl;
      bus.wstall   = (c >= v.stall_at) && (c < v.stall_at + v.stall_len);
      bus.in_valid = 1'b1;
      {bus.in_res1, bus.in_res0} = beat_data;
      #1;
      exp_busy = (done_obs < 0);
      check_output({tag, " busy"}, 64'(busy), 64'(exp_busy));
      skid = k - completed - (bus.wen ? 1 : 0);
      check_output({tag, " in_ready"}, 64'(bus.in_ready), 64'(exp_busy && (k < v.exp_n) && (skid < 2)));
      cur = '{bus.wreg, bus.wbeat, bus.wdata, bus.wstrb};
      if (prev_stalled) begin
        check_output({tag, " wen held"}, 64'(bus.wen), 64'd1);
        check_output({tag, " fields held"}, 64'(cur == prev), 64'd1);
      end
      if (bus.wen && first_wen < 0) first_wen = c;
      if (bus.wen && !bus.wstall) begin
        completed++;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL %s unexpected write: wreg %0d wstrb %0h, expected none", tag, bus.wreg, bus.wstrb);
        end else begin
          exp_w = sb.pop_front();
          check_output({tag, " wreg"},  64'(bus.wreg),  64'(exp_w.wreg));
          check_output({tag, " wbeat"}, 64'(bus.wbeat), 64'(exp_w.wbeat));
          check_output({tag, " wdata"}, bus.wdata,      exp_w.wdata);
          check_output({tag, " wstrb"}, 64'(bus.wstrb), 64'(exp_w.wstrb));
        end
        if (writes == 0) first_strb = bus.wstrb;
        writes++;
        last_strb = bus.wstrb;
        last_reg  = bus.wreg;
        last_c    = c;
      end
      prev_stalled = bus.wen && bus.wstall;
      prev = cur;
      if (bus.in_valid && bus.in_ready) begin
        exp_w.wreg  = v.vd + 5'(k / BPR);
        exp_w.wbeat = BEAT_W'(k % BPR);
        exp_w.wdata = beat_data;
        exp_w.wstrb = model_strb(k, v.sew, v.vl, v.vm, v.vmask);
        sb.push_back(exp_w);
        if (first_acc < 0) first_acc = c;
        k++;
        beat_data = {$urandom, $urandom};
      end
      if (done) begin
        done_cnt++;
        if (done_obs < 0) done_obs = c;
      end
      if (done_obs >= 0 && c == done_obs + 2) finished = 1;
    end
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.wstall = 1'b0;
    if (!finished) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s timeout: done not seen within 300 cycles, expected a done pulse", tag);
    end
    check_output({tag, " write count"}, 64'(writes), 64'(v.exp_n));
    check_output({tag, " done pulses"}, 64'(done_cnt), 64'd1);
    check_output({tag, " busy at end"}, 64'(busy), 64'd0);
    check_output({tag, " scoreboard empty"}, 64'(sb.size()), 64'd0);
    if (v.exp_n > 0) begin
      check_output({tag, " first wstrb"}, 64'(first_strb), 64'(v.strb_first));
      check_output({tag, " last wstrb"}, 64'(last_strb), 64'(v.strb_last));
      check_output({tag, " last wreg"}, 64'(last_reg), 64'(v.reg_last));
      check_output({tag, " done timing"}, 64'(done_obs), 64'(last_c + 2));
      check_output({tag, " first latency"}, 64'(first_wen), 64'(first_acc + 2));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, " in_ready"}, 64'(bus.in_ready), 64'd0);
    check_output({tag, " wen"},      64'(bus.wen),      64'd0);
    check_output({tag, " wreg"},     64'(bus.wreg),     64'd0);
    check_output({tag, " wbeat"},    64'(bus.wbeat),    64'd0);
    check_output({tag, " wdata"},    bus.wdata,         64'd0);
    check_output({tag, " wstrb"},    64'(bus.wstrb),    64'd0);
    check_output({tag, " busy"},     64'(busy),         64'd0);
    check_output({tag, " done"},     64'(done),         64'd0);
  endtask

  initial begin
    vecs[0] = '{5'd8,  2'd2, 7'd4,  1'b1, 64'd0,                  2, 8'hFF, 8'hFF, 5'd8,  -1, 0, -1};
    vecs[1] = '{5'd3,  2'd0, 7'd5,  1'b1, 64'd0,                  1, 8'h1F, 8'h1F, 5'd3,  -1, 0, -1};
    vecs[2] = '{5'd4,  2'd1, 7'd8,  1'b0, 64'h5A,                 2, 8'hCC, 8'h33, 5'd4,  -1, 0, -1};
    vecs[3] = '{5'd10, 2'd2, 7'd8,  1'b1, 64'd0,                  4, 8'hFF, 8'hFF, 5'd11,  2, 3, -1};
    vecs[4] = '{5'd0,  2'd2, 7'd0,  1'b1, 64'd0,                  0, 8'h00, 8'h00, 5'd0,  -1, 0, -1};
    vecs[5] = '{5'd31, 2'd2, 7'd8,  1'b1, 64'd0,                  4, 8'hFF, 8'hFF, 5'd0,  -1, 0, -1};
    vecs[6] = '{5'd20, 2'd0, 7'd64, 1'b0, 64'hF0F0_1234_5678_9ABC, 8, 8'hBC, 8'hF0, 5'd23,  5, 2, -1};
    vecs[7] = '{5'd1,  2'd1, 7'd7,  1'b1, 64'd0,                  2, 8'hFF, 8'h3F, 5'd1,  -1, 0,  3};
    vecs[8] = '{5'd6,  2'd3, 7'd3,  1'b0, 64'h5,                  2, 8'h0F, 8'h0F, 5'd6,  -1, 0, -1};

    nRST = 1'b0; start = 1'b0; vd = '0; sew = '0; vl = '0; vm = 1'b0; vmask = '0;
    bus.in_valid = 1'b0; bus.in_res0 = '0; bus.in_res1 = '0; bus.wstall = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    check_reset_outputs("reset");
    @(negedge CLK);
    nRST = 1'b1;

    // Reset in the middle of an operation after one beat has been accepted
    @(negedge CLK);
    start = 1'b1; vd = 5'd2; sew = 2'd2; vl = 7'd8; vm = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    bus.in_valid = 1'b1; {bus.in_res1, bus.in_res0} = 64'hDEAD_BEEF_0123_4567;
    @(negedge CLK);
    bus.in_valid = 1'b0;
    @(negedge CLK);
    #1;
    check_output("midrun wen", 64'(bus.wen), 64'd1);
    check_output("midrun wdata", bus.wdata, 64'hDEAD_BEEF_0123_4567);
    nRST = 1'b0;
    #1;
    check_reset_outputs("midrun reset");
    @(negedge CLK);
    nRST = 1'b1;

    for (int t = 0; t < 9; t++) begin
      apply_stimulus(vecs[t], $sformatf("vec%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iota_wb_sequencer.md
# iota_wb_sequencer

Writeback stage directly downstream of the mask-unit iota engine in the rv32v lane. Accepts the packed per-cycle iota results (two 32-bit words holding 2/4/8 elements depending on SEW), applies vl tail and v0.t masking, and issues byte-strobed 64-bit writes into the vector register file across the destination register group. Provides a valid/ready input handshake with a 2-entry skid buffer so the producer can be stalled by VRF back-pressure.

## Interface
- VLEN, 128: vector register length in bits; must be a multiple of 64; BEATS_PER_REG = VLEN/64.
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse latching vd, sew, vl, vm, vmask; ignored while busy=1
- vd  in  5  destination base register
- sew  in  2  element width (rv32v_types_pkg: SEW8/SEW16/SEW32)
- vl  in  7  active element count, 0..64
- vm  in  1  1 = unmasked, 0 = masked by vmask
- vmask  in  64  v0 mask bits, bit i governs element i
- in_valid  in  1  result beat valid
- in_res0  in  32  low result word (elements packed from bit 0)
- in_res1  in  32  high result word
- in_ready  out  1  beat accepted when in_valid & in_ready
- wstall  in  1  VRF cannot accept a write this cycle
- wen  out  1  write valid
- wreg  out  5  target register
- wbeat  out  log2(BEATS_PER_REG) (min 1)  64-bit slot within register
- wdata  out  64  {in_res1, in_res0}
- wstrb  out  8  byte enables
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse

## Operation
- E = elements per beat: SEW32→2, SEW16→4, SEW8→8; bytes per element B = 8/E. Other sew encodings: treat as SEW32.
- Total beats N = ceil(vl/E) (vl=0 → N=0).
- FSM: IDLE → RUN on start (latch config; in_cnt=out_cnt=0). RUN → DRAIN when in_cnt reaches N. DRAIN → DONE when out_cnt reaches N. DONE → IDLE unconditionally (done=1 in DONE). vl=0: IDLE→RUN→DRAIN→DONE with no writes, in_ready never asserted.
- in_ready = (state==RUN) & (in_cnt < N) & (skid entries < 2). Beats past N are not accepted.
- Each accepted beat k is pushed with its index k; skid FIFO depth 2, FIFO ordering.
- Write for beat k: wreg = (vd + k / BEATS_PER_REG) mod 32 (5-bit wrap); wbeat = k mod BEATS_PER_REG.
- Element i = k*E + j occupies bytes [j*B, j*B+B). Its strobe bits = 1 iff i < vl and (vm | vmask[i]); else 0 (undisturbed tail/masked). A beat with wstrb=0 is still issued with wen=1.
- out_cnt increments on each cycle with wen & ~wstall.
- start while busy ignored; no effect on state.
- nRST low at any time: all state cleared, returns to IDLE, skid emptied, operation discarded.

## Timing
- Reset values: in_ready=0, wen=0, wreg=0, wbeat=0, wdata=0, wstrb=0, busy=0, done=0.
- busy=1 from the cycle after start through the DONE cycle inclusive.
- Latency: beat accepted at edge t appears on wen/wdata/wstrb from edge t+1 (registered output), if the output register is empty or draining.
- wstall=1: wen and all write fields hold stable; incoming beats fill skid; in_ready drops once 2 entries held; no beat lost or duplicated.
- Sustained throughput 1 beat/cycle with wstall=0.
- done asserted exactly one cycle, the cycle after the last write completes (last write accepted at edge t → done high during cycle t+1 to t+2).
- Simultaneous push and pop of skid in the same cycle: occupancy unchanged.

## Test plan
- SEW32, vl=4, vm=1, vd=8, beats {1,0},{3,2} back-to-back -> writes reg8 beat0 wstrb=FF, reg8 beat1 wstrb=FF, done one cycle later, in_ready=0 after 2nd beat.
- SEW8, vl=5, vm=1 -> one beat, wstrb=0x1F; second in_valid beat not accepted.
- SEW16, vl=8, vm=0, vmask=0x5A -> beat0 wstrb=0xCC... exactly: beat0 elems0..3 mask 1010→wstrb=0xCC, beat1 elems4..7 mask 0101→wstrb=0x33.
- SEW32, vl=8, wstall held 3 cycles during beat1 with in_valid continuous -> in_ready drops after 2 skid entries, all 4 writes emitted in order with regs vd,vd,vd+1,vd+1, wdata unchanged while stalled.
- vl=0 start -> no wen, in_ready stays 0, done pulse, busy returns 0; vd=31, SEW32 vl=8 -> wreg wraps 31,31,0,0.
- nRST asserted mid-RUN after 1 beat -> all outputs at reset values immediately; next start runs cleanly from in_cnt=0.
